// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared CPU constants: register-bank geometry and write-back stream IDs.
package regbank_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 16;

    // Stream identifiers, also used as the encoding of last_grant.
    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_MEM = 1'b1;

endpackage

// File: rtl/regbank_wb_arbiter_wb_slot.sv
// One-entry write-back holding slot. Accepts when empty or when draining
// this cycle, so a saturated, uncontended stream sustains one per cycle.
module wb_slot
    import regbank_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              drain,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    assign in_ready = !full || drain;

    // Capture on accept; otherwise a drain empties the slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (in_valid && in_ready) begin
            full <= 1'b1;
            addr <= in_addr;
            data <= in_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Write-back arbiter for the register bank's single write port plus the
// in-flight load scoreboard that drives the decode read-hazard stall.
module regbank_wb_arbiter
    import regbank_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              stall,
    output logic              rb_we,
    output logic [ADDR_W-1:0] rb_addr_d,
    output logic [DATA_W-1:0] rb_data_d,
    output logic              busy
);

    localparam int NREGS = 1 << ADDR_W;

    logic              alu_full, mem_full;
    logic [ADDR_W-1:0] alu_addr_q, mem_addr_q;
    logic [DATA_W-1:0] alu_data_q, mem_data_q;
    logic              grant_alu, grant_mem;
    logic              last_grant;
    logic [NREGS-1:0]  pending, pending_set, pending_clr;
    logic              stall_a, stall_b;

    wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_alu_slot (
        .clk(clk), .reset(reset),
        .in_valid(alu_valid), .in_ready(alu_ready),
        .in_addr(alu_addr), .in_data(alu_data),
        .drain(grant_alu),
        .full(alu_full), .addr(alu_addr_q), .data(alu_data_q)
    );

    wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem_slot (
        .clk(clk), .reset(reset),
        .in_valid(mem_valid), .in_ready(mem_ready),
        .in_addr(mem_addr), .in_data(mem_data),
        .drain(grant_mem),
        .full(mem_full), .addr(mem_addr_q), .data(mem_data_q)
    );

    // Grant: lone full slot wins; same-address tie goes to the older load so
    // the ALU value lands last; otherwise round-robin against last_grant.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (alu_full && mem_full) begin
            if (alu_addr_q == mem_addr_q)      grant_mem = 1'b1;
            else if (last_grant == WB_SRC_MEM) grant_alu = 1'b1;
            else                               grant_mem = 1'b1;
        end else begin
            grant_alu = alu_full;
            grant_mem = mem_full;
        end
    end

    // Write-port mux; idle port drives zeros. Address 0 drains without a write.
    always_comb begin
        rb_addr_d = '0;
        rb_data_d = '0;
        if (grant_mem) begin
            rb_addr_d = mem_addr_q;
            rb_data_d = mem_data_q;
        end else if (grant_alu) begin
            rb_addr_d = alu_addr_q;
            rb_data_d = alu_data_q;
        end
        rb_we = (grant_alu || grant_mem) && (rb_addr_d != '0);
    end

    // Remember which stream was served last for round-robin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         last_grant <= WB_SRC_MEM;
        else if (grant_alu) last_grant <= WB_SRC_ALU;
        else if (grant_mem) last_grant <= WB_SRC_MEM;
    end

    // Scoreboard set/clear masks; r0 never becomes pending.
    always_comb begin
        pending_set = '0;
        pending_clr = '0;
        if (issue_valid && issue_addr != '0) pending_set[issue_addr] = 1'b1;
        if (grant_mem) pending_clr[mem_addr_q] = 1'b1;
    end

    // Set wins over a same-cycle clear of the same bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending <= '0;
        else        pending <= ((pending & ~pending_clr) | pending_set) & ~NREGS'(1);
    end

    // Hazard: source is a pending load or sits in a not-yet-written slot.
    // The slot stays full through its drain cycle, covering the write cycle.
    always_comb begin
        stall_a = (rd_addr_a != '0) &&
                  (pending[rd_addr_a] ||
                   (alu_full && alu_addr_q == rd_addr_a) ||
                   (mem_full && mem_addr_q == rd_addr_a));
        stall_b = (rd_addr_b != '0) &&
                  (pending[rd_addr_b] ||
                   (alu_full && alu_addr_q == rd_addr_b) ||
                   (mem_full && mem_addr_q == rd_addr_b));
        stall   = stall_a || stall_b;
        busy    = alu_full || mem_full || (pending != '0);
    end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed self-checking bench for regbank_wb_arbiter.
module tb_regbank_wb_arbiter;

    logic        clk, reset;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [3:0]  alu_addr, mem_addr, issue_addr, rd_addr_a, rd_addr_b, rb_addr_d;
    logic [31:0] alu_data, mem_data, rb_data_d;
    logic        issue_valid, stall, rb_we, busy;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;
    logic [31:0] bank [16];

    regbank_wb_arbiter #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .stall(stall),
        .rb_we(rb_we), .rb_addr_d(rb_addr_d), .rb_data_d(rb_data_d), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-bank stand-in: records writes as the bank would.
    always @(posedge clk) begin
        if (rb_we) begin
            bank[rb_addr_d] <= rb_data_d;
            wr_count <= wr_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        issue_valid = 0; issue_addr = 0;
        rd_addr_a = 0; rd_addr_b = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        tick();
        reset = 1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        #3;
        tests++;
        if ({rb_we, rb_addr_d, rb_data_d, stall, busy, alu_ready, mem_ready} !==
            {1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            $display("FAIL reset_outputs: we=%b addr=%0d data=%h stall=%b busy=%b ar=%b mr=%b, want 0 0 0 0 0 1 1",
                     rb_we, rb_addr_d, rb_data_d, stall, busy, alu_ready, mem_ready);
            fails++;
        end
        tick();
        reset = 1;
        #1;
    endtask

    task automatic test_alu_single();
        alu_valid = 1; alu_addr = 3; alu_data = 32'h11; rd_addr_b = 3;
        #1;
        tests++;
        if ({alu_ready, rb_we, stall} !== 3'b100) begin
            $display("FAIL alu_pre: ready=%b we=%b stall=%b, want 1 0 0", alu_ready, rb_we, stall);
            fails++;
        end
        tick();
        alu_valid = 0;
        #1;
        tests++;
        if ({rb_we, rb_addr_d, rb_data_d, alu_ready, busy, stall} !== {1'b1, 4'd3, 32'h11, 1'b1, 1'b1, 1'b1}) begin
            $display("FAIL alu_write: we=%b addr=%0d data=%h ready=%b busy=%b stall=%b, want 1 3 11 1 1 1",
                     rb_we, rb_addr_d, rb_data_d, alu_ready, busy, stall);
            fails++;
        end
        tick();
        tests++;
        if ({rb_we, busy, stall} !== 3'b000 || bank[3] !== 32'h11) begin
            $display("FAIL alu_after: we=%b busy=%b stall=%b r3=%h, want 0 0 0 11", rb_we, busy, stall, bank[3]);
            fails++;
        end
        idle_inputs();
    endtask

    task automatic test_tie_round_robin();
        do_reset();
        alu_valid = 1; alu_addr = 2; alu_data = 32'hA;
        mem_valid = 1; mem_addr = 5; mem_data = 32'hB;
        tick();
        alu_valid = 0;
        mem_addr = 6; mem_data = 32'hC;
        #1;
        tests++;
        if ({rb_we, rb_addr_d, rb_data_d, mem_ready} !== {1'b1, 4'd2, 32'hA, 1'b0}) begin
            $display("FAIL tie_first: we=%b addr=%0d data=%h mready=%b, want 1 2 a 0",
                     rb_we, rb_addr_d, rb_data_d, mem_ready);
            fails++;
        end
        tick();
        tests++;
        if ({rb_we, rb_addr_d, rb_data_d, mem_ready} !== {1'b1, 4'd5, 32'hB, 1'b1}) begin
            $display("FAIL tie_second: we=%b addr=%0d data=%h mready=%b, want 1 5 b 1",
                     rb_we, rb_addr_d, rb_data_d, mem_ready);
            fails++;
        end
        tick();
        mem_valid = 0;
        #1;
        tests++;
        if ({rb_we, rb_addr_d, rb_data_d} !== {1'b1, 4'd6, 32'hC}) begin
            $display("FAIL tie_refill: we=%b addr=%0d data=%h, want 1 6 c", rb_we, rb_addr_d, rb_data_d);
            fails++;
        end
        tick();
        tests++;
        if ({rb_we, busy} !== 2'b00) begin
            $display("FAIL tie_idle: we=%b busy=%b, want 0 0", rb_we, busy);
            fails++;
        end
    endtask

    task automatic test_same_addr();
        alu_valid = 1; alu_addr = 7; alu_data = 32'h1;
        mem_valid = 1; mem_addr = 7; mem_data = 32'h2;
        tick();
        alu_valid = 0; mem_valid = 0;
        #1;
        tests++;
        if ({rb_we, rb_addr_d, rb_data_d} !== {1'b1, 4'd7, 32'h2}) begin
            $display("FAIL same_first: we=%b addr=%0d data=%h, want 1 7 2", rb_we, rb_addr_d, rb_data_d);
            fails++;
        end
        tick();
        tests++;
        if ({rb_we, rb_addr_d, rb_data_d} !== {1'b1, 4'd7, 32'h1}) begin
            $display("FAIL same_second: we=%b addr=%0d data=%h, want 1 7 1", rb_we, rb_addr_d, rb_data_d);
            fails++;
        end
        tick();
        tests++;
        if (bank[7] !== 32'h1 || rb_we !== 1'b0) begin
            $display("FAIL same_final: r7=%h we=%b, want 1 0", bank[7], rb_we);
            fails++;
        end
    endtask

    task automatic test_load_stall();
        issue_valid = 1; issue_addr = 4;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            $display("FAIL load_issue: stall=%b, want 0", stall);
            fails++;
        end
        tick();
        issue_valid = 0; rd_addr_a = 4;
        #1;
        tests++;
        if ({stall, busy} !== 2'b11) begin
            $display("FAIL load_pending: stall=%b busy=%b, want 1 1", stall, busy);
            fails++;
        end
        tick();
        mem_valid = 1; mem_addr = 4; mem_data = 32'h44;
        tick();
        mem_valid = 0;
        #1;
        tests++;
        if ({rb_we, rb_addr_d, rb_data_d, stall} !== {1'b1, 4'd4, 32'h44, 1'b1}) begin
            $display("FAIL load_write: we=%b addr=%0d data=%h stall=%b, want 1 4 44 1",
                     rb_we, rb_addr_d, rb_data_d, stall);
            fails++;
        end
        tick();
        tests++;
        if ({stall, busy, rb_we} !== 3'b000) begin
            $display("FAIL load_release: stall=%b busy=%b we=%b, want 0 0 0", stall, busy, rb_we);
            fails++;
        end
        idle_inputs();
    endtask

    task automatic test_set_wins();
        issue_valid = 1; issue_addr = 8;
        tick();
        issue_valid = 0;
        mem_valid = 1; mem_addr = 8; mem_data = 32'h80;
        tick();
        mem_valid = 0;
        issue_valid = 1; issue_addr = 8;  // re-issue while the old load drains
        tick();
        issue_valid = 0; rd_addr_b = 8;
        #1;
        tests++;
        if ({stall, busy, rb_we} !== 3'b110) begin
            $display("FAIL set_wins: stall=%b busy=%b we=%b, want 1 1 0", stall, busy, rb_we);
            fails++;
        end
        mem_valid = 1; mem_addr = 8; mem_data = 32'h81;
        tick();
        mem_valid = 0;
        tick();
        tests++;
        if ({stall, busy} !== 2'b00 || bank[8] !== 32'h81) begin
            $display("FAIL set_wins_clear: stall=%b busy=%b r8=%h, want 0 0 81", stall, busy, bank[8]);
            fails++;
        end
        idle_inputs();
    endtask

    task automatic test_r0();
        int wc;
        wc = wr_count;
        alu_valid = 1; alu_addr = 0; alu_data = 32'hFF;
        issue_valid = 1; issue_addr = 0;
        rd_addr_a = 0;
        #1;
        tests++;
        if (alu_ready !== 1'b1) begin
            $display("FAIL r0_ready: ready=%b, want 1", alu_ready);
            fails++;
        end
        tick();
        alu_valid = 0; issue_valid = 0;
        #1;
        tests++;
        if ({rb_we, stall, busy} !== 3'b001) begin
            $display("FAIL r0_drain: we=%b stall=%b busy=%b, want 0 0 1", rb_we, stall, busy);
            fails++;
        end
        tick();
        tests++;
        if ({busy, stall} !== 2'b00 || wr_count !== wc) begin
            $display("FAIL r0_after: busy=%b stall=%b writes=%0d, want 0 0 %0d", busy, stall, wr_count, wc);
            fails++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int wc;
        do_reset();
        issue_valid = 1; issue_addr = 9;
        alu_valid = 1; alu_addr = 1; alu_data = 32'h5;
        mem_valid = 1; mem_addr = 2; mem_data = 32'h6;
        tick();
        idle_inputs();
        rd_addr_a = 9;
        #1;
        tests++;
        if ({rb_we, stall, busy} !== 3'b111) begin
            $display("FAIL mid_before: we=%b stall=%b busy=%b, want 1 1 1", rb_we, stall, busy);
            fails++;
        end
        #1;
        reset = 0;
        #1;
        tests++;
        if ({rb_we, rb_addr_d, rb_data_d, stall, busy, alu_ready, mem_ready} !==
            {1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            $display("FAIL mid_reset: we=%b addr=%0d data=%h stall=%b busy=%b ar=%b mr=%b, want 0 0 0 0 0 1 1",
                     rb_we, rb_addr_d, rb_data_d, stall, busy, alu_ready, mem_ready);
            fails++;
        end
        wc = wr_count;
        tick();
        reset = 1;
        tick();
        tests++;
        if (wr_count !== wc || rb_we !== 1'b0) begin
            $display("FAIL mid_nowrite: writes=%0d we=%b, want %0d 0", wr_count, rb_we, wc);
            fails++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) bank[i] = '0;
        test_reset();
        test_alu_single();
        test_tie_round_robin();
        test_same_addr();
        test_load_stall();
        test_set_wins();
        test_r0();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
